// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// fetch buffer entry layout and the fetch-target legality rule.
package instr_fetch_ctrl_pkg;

    localparam logic [31:0] NOP                = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEFAULT_IMEM_WORDS = 512;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A target is fetchable when word aligned and inside the instruction memory.
    function automatic logic is_legal_target(input logic [31:0] pc, input int unsigned words);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < words);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {PC, instruction} entries; flush overrides push and pop.
module fetch_fifo
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t      mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so
    // stale contents are never observed and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, fills the fetch buffer from instruction
// memory and handles redirect, halt and illegal-target trapping.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Halt,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPC,
    output logic [31:0] OutPCPlus4,
    output logic        Fault,
    output logic [31:0] FaultPC
);

    fetch_state_e state;
    logic [31:0]  fetch_pc;
    logic [31:0]  next_pc;
    logic         fault_q;
    logic [31:0]  fault_pc_q;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         flush;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    always_comb begin
        next_pc  = fetch_pc + 32'd4;
        pop      = !fifo_empty && OutReady;
        flush    = Redirect && (state != ST_FAULT);
        push     = (state == ST_RUN) && !Redirect && (!fifo_full || pop);
        wr_entry = '{pc: fetch_pc, instr: ImemInstruction};
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (Clk),
        .reset    (Reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_RUN;
            fetch_pc   <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            unique case (state)
                ST_RUN, ST_HALTED: begin
                    if (Redirect) begin
                        // Halt state is preserved across a legal redirect.
                        if (is_legal_target(RedirectPC, IMEM_WORDS)) begin
                            fetch_pc <= RedirectPC;
                        end else begin
                            state      <= ST_FAULT;
                            fault_q    <= 1'b1;
                            fault_pc_q <= RedirectPC;
                        end
                    end else begin
                        if (push) fetch_pc <= next_pc;
                        if (push && !is_legal_target(next_pc, IMEM_WORDS)) begin
                            state      <= ST_FAULT;
                            fault_q    <= 1'b1;
                            fault_pc_q <= next_pc;
                        end else begin
                            state <= Halt ? ST_HALTED : ST_RUN;
                        end
                    end
                end
                default: begin
                    // Trapped: only Reset leaves this state; the buffer drains.
                    state <= ST_FAULT;
                end
            endcase
        end
    end

    assign ImemAddress    = fetch_pc;
    assign OutValid       = !fifo_empty;
    assign OutInstruction = fifo_empty ? NOP : head.instr;
    assign OutPC          = fifo_empty ? 32'h0 : head.pc;
    assign OutPCPlus4     = OutPC + 32'd4;
    assign Fault          = fault_q;
    assign FaultPC        = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed scenarios then random
// redirect/halt/ready traffic against an abstract queue-based fetch model.
module tb_instr_fetch_ctrl;

    localparam int unsigned TB_WORDS = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] START_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] imem [TB_WORDS];

    // Reference model state
    exp_t        exp_q [$];
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    int          m_count;
    bit          m_halted;
    bit          m_faulted;
    bit          mon_en = 1'b0;

    int checks      = 0;
    int errors      = 0;
    int delivered   = 0;
    int faults_seen = 0;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr[31:7] == '0) ? imem[imem_addr[6:2]] : 32'hDEAD_BEEF;

    instr_fetch_ctrl #(
        .RESET_PC   (START_PC),
        .IMEM_WORDS (TB_WORDS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk             (clk),
        .Reset           (reset),
        .ImemAddress     (imem_addr),
        .ImemInstruction (imem_rdata),
        .Redirect        (redirect),
        .RedirectPC      (redirect_pc),
        .Halt            (halt),
        .OutValid        (out_valid),
        .OutReady        (out_ready),
        .OutInstruction  (out_instr),
        .OutPC           (out_pc),
        .OutPCPlus4      (out_pc4),
        .Fault           (fault),
        .FaultPC         (fault_pc)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < TB_WORDS);
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit pop;
        bit do_push;
        if (reset) begin
            m_pc      = START_PC;
            m_count   = 0;
            m_halted  = 1'b0;
            m_faulted = 1'b0;
            exp_q.delete();
        end else begin
            pop = (m_count > 0) && out_ready;
            if (redirect && !m_faulted) begin
                m_count = 0;
                exp_q.delete();
                if (legal(redirect_pc)) begin
                    m_pc = redirect_pc;
                end else begin
                    m_faulted = 1'b1;
                    m_fpc     = redirect_pc;
                    faults_seen++;
                end
            end else begin
                do_push = !m_faulted && !m_halted && (m_count < DEPTH || pop);
                if (pop) m_count--;
                if (do_push) begin
                    exp_q.push_back('{pc: m_pc, instr: imem[m_pc / 4]});
                    m_count++;
                    m_pc = m_pc + 32'd4;
                    if (!legal(m_pc)) begin
                        m_faulted = 1'b1;
                        m_fpc     = m_pc;
                        faults_seen++;
                    end
                end
                if (!m_faulted) m_halted = halt;
            end
        end
    endtask

    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                        input bit hlt, input bit rdy);
        reset       = rst;
        redirect    = redir;
        redirect_pc = rpc;
        halt        = hlt;
        out_ready   = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: compares DUT outputs mid-cycle and retires accepted entries.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(m_count > 0));
            check("imem_address", imem_addr, m_pc);
            check("fault", 32'(fault), 32'(m_faulted));
            if (m_faulted) check("fault_pc", fault_pc, m_fpc);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got pc %h with nothing expected at %0t", out_pc, $time);
                end else begin
                    e = exp_q[0];
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                    check("out_pc_plus4", out_pc4, e.pc + 32'd4);
                    if (out_ready && !reset && !(redirect && !m_faulted)) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    initial begin
        bit          hl;
        bit          rs;
        bit          rd;
        bit          rdy;
        logic [31:0] tgt;

        for (int i = 0; i < int'(TB_WORDS); i++) imem[i] = $urandom;

        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_pc_plus4", out_pc4, 32'h4);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_pc", fault_pc, 32'h0);
        check("rst_imem_address", imem_addr, START_PC);
        mon_en = 1'b1;

        // Streaming from reset, then a stall, then resume.
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Fill, then redirect while full with the head being accepted.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("redir_head_pc", out_pc, 32'h40);
        check("redir_head_instr", out_instr, imem[16]);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Halt with ready high, then release.
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("halt_drained", 32'(out_valid), 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Misaligned redirect traps; later redirects are ignored.
        step(1'b0, 1'b1, 32'h42, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("illegal_fault", 32'(fault), 32'h1);
        check("illegal_fault_pc", fault_pc, 32'h42);
        check("illegal_drained", 32'(out_valid), 32'h0);

        // Sequential overrun off the end of the memory.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h70, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("overrun_fault", 32'(fault), 32'h1);
        check("overrun_fault_pc", fault_pc, 32'h80);
        check("overrun_drained", 32'(out_valid), 32'h0);

        // Random traffic.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        hl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 199) == 0) || (m_faulted && $urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 7))
                0:       tgt = $urandom;
                1:       tgt = $urandom_range(0, TB_WORDS - 1) * 4 + $urandom_range(1, 3);
                2:       tgt = $urandom_range(TB_WORDS, TB_WORDS + 8) * 4;
                default: tgt = $urandom_range(0, TB_WORDS - 1) * 4;
            endcase
            if ($urandom_range(0, 9) == 0) hl = !hl;
            rdy = ($urandom_range(0, 3) != 0);
            step(rs, rd, tgt, hl, rdy);
        end

        check("enough_delivered", 32'(delivered > 500), 32'h1);
        check("faults_exercised", 32'(faults_seen > 3), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
